// File: rtl/execute_stage.sv
// execute_stage: execute/writeback stage that sits behind the register file.
// Single-cycle ALU ops (ADD, SUB, AND, OR, XOR, SHL, SHR) write back on the
// cycle after accept; MUL runs a shift-add loop, one multiplier bit per
// cycle, and writes back after WIDTH iterations. Operands are forwarded
// from the result currently on the write port to cover back-to-back
// read-after-write hazards.
//
// Handshake: `start` is a request that is accepted on a rising clock edge
// only when `ready` is 1 at that edge. A `start` seen while `ready` is 0 is
// dropped (no queuing). Each accepted op produces exactly one one-cycle
// `writeEn` pulse carrying `dest`/`data`/`carry`.
module execute_stage #(
    parameter int WIDTH = 8,
    parameter int AW    = 3,
    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    rsAddr,
    input  logic [AW-1:0]    rdAddr,
    input  logic [WIDTH-1:0] rsVal,
    input  logic [WIDTH-1:0] rdVal,
    input  logic [AW-1:0]    destIn,
    output logic             ready,
    output logic             writeEn,
    output logic [AW-1:0]    dest,
    output logic [WIDTH-1:0] data,
    output logic             carry,
    output logic             dbgState,
    output logic [CW-1:0]    dbgCount
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state, state_next;

    // Multiply working registers
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [AW-1:0]      mul_dest;

    // Forwarded operands and accept strobe
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             accept;
    logic             last_iter;
    logic [2*WIDTH-1:0] mul_sum;

    // ALU result for the single-cycle ops
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [2:0]       shamt;

    // Operand selection: the result on the write port this cycle is the one
    // the register file writes on the accepting edge, so it wins over the
    // (stale) register file output.
    always_comb begin
        op_a      = (writeEn && (dest == rsAddr)) ? data : rsVal;
        op_b      = (writeEn && (dest == rdAddr)) ? data : rdVal;
        accept    = start && ready;
        last_iter = (cnt == LAST_ITER);
        mul_sum   = acc + (mplier[0] ? mcand : '0);
    end

    // Single-cycle ALU. Shifts carry out the last bit that left the word:
    // the extra bit of the widened vector holds exactly that bit, and is 0
    // when the shift amount is 0.
    always_comb begin
        shamt    = op_b[2:0];
        sum_ext  = {1'b0, op_a} + {1'b0, op_b};
        diff_ext = {1'b0, op_a} - {1'b0, op_b};
        shl_ext  = {1'b0, op_a} << shamt;
        shr_ext  = {op_a, 1'b0} >> shamt;
        alu_res  = '0;
        alu_c    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: MUL occupies the stage until its last iteration
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && (op == OP_MUL)) begin
                    state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (last_iter) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: ready only while idle; state and counter exposed for debug
    always_comb begin
        ready    = (state == S_IDLE);
        dbgState = state;
        dbgCount = cnt;
    end

    // Datapath: operand capture, multiply iterations and the write port.
    // dest/data/carry only change on the edge that raises writeEn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            writeEn  <= 1'b0;
            dest     <= '0;
            data     <= '0;
            carry    <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            mul_dest <= '0;
        end else begin
            writeEn <= 1'b0;
            if (state == S_IDLE) begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mcand    <= {{WIDTH{1'b0}}, op_a};
                        mplier   <= op_b;
                        acc      <= '0;
                        cnt      <= '0;
                        mul_dest <= destIn;
                    end else begin
                        writeEn <= 1'b1;
                        dest    <= destIn;
                        data    <= alu_res;
                        carry   <= alu_c;
                    end
                end
            end else begin
                if (last_iter) begin
                    writeEn <= 1'b1;
                    dest    <= mul_dest;
                    data    <= mul_sum[WIDTH-1:0];
                    carry   <= |mul_sum[2*WIDTH-1:WIDTH];
                    cnt     <= '0;
                end else begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
